// File: rtl/p4_mem_access.sv
// P4 memory-access stage: issues loads/stores on a req/gnt + rvalid data bus, aligns load data, registers P4->P5.
// Optional `MEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap with o_bus_err instead of touching the bus.

package p4_mem_access_pkg;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc_next;
        logic [31:0] reg_rd_data2;
        ctrl_t       ctrl;
        logic [31:0] alu_out;
        logic [31:0] insn;
    } p3p4_t;

    typedef struct packed {
        logic [31:0] pc_next;
        ctrl_t       ctrl;
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
        logic [31:0] insn;
    } p4p5_t;

    localparam p4p5_t P4P5_BUBBLE = '{
        pc_next:   32'h0,
        ctrl:      '0,
        alu_out:   32'h0,
        mem_rdata: 32'h0,
        insn:      32'h0000_0013
    };

endpackage

module p4_mem_access
    import p4_mem_access_pkg::*;
#(
    parameter int unsigned DBUS_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  p3p4_t       i_p3p4,
    output p4p5_t       o_p4p5,
    output logic        o_stall,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    output logic [3:0]  o_dbus_wstrb,
    input  logic        i_dbus_gnt,
    input  logic        i_dbus_rvalid,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_bus_err
);

    localparam int CNT_W = (DBUS_TIMEOUT < 2) ? 1 : $clog2(DBUS_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    p4p5_t              p4p5_q, p4p5_d;

    logic        mem_op, is_store, misalign, timeout;
    logic        req, complete, abort, capture_rdata, stall;
    logic [1:0]  a_lo;
    logic [2:0]  funct3;
    logic [31:0] load_data, store_data;
    logic [3:0]  store_strb;

    assign mem_op   = i_p3p4.ctrl.mem_read | i_p3p4.ctrl.mem_write;
    assign is_store = i_p3p4.ctrl.mem_write;
    assign a_lo     = i_p3p4.alu_out[1:0];
    assign funct3   = i_p3p4.insn[14:12];
    assign timeout  = (cnt_q == CNT_W'(DBUS_TIMEOUT));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op & (((funct3[1:0] == 2'b01) & a_lo[0]) |
                                ((funct3[1:0] == 2'b10) & (a_lo != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Size comes from funct3[1:0]; bit 2 only selects zero-extension for loads.
    always_comb begin
        store_strb = 4'hF;
        store_data = i_p3p4.reg_rd_data2;
        unique case (funct3[1:0])
            2'b00: begin
                store_strb = 4'b0001 << a_lo;
                store_data = {4{i_p3p4.reg_rd_data2[7:0]}};
            end
            2'b01: begin
                store_strb = 4'b0011 << {a_lo[1], 1'b0};
                store_data = {2{i_p3p4.reg_rd_data2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [31:0] b_lane, h_lane;
        b_lane = i_dbus_rdata >> {a_lo, 3'b000};
        h_lane = i_dbus_rdata >> {a_lo[1], 4'b0000};
        unique case (funct3)
            3'b000:  load_data = {{24{b_lane[7]}}, b_lane[7:0]};
            3'b001:  load_data = {{16{h_lane[15]}}, h_lane[15:0]};
            3'b100:  load_data = {24'h0, b_lane[7:0]};
            3'b101:  load_data = {16'h0, h_lane[15:0]};
            default: load_data = i_dbus_rdata;
        endcase
    end

    // The IDLE cycle that sees a mem op already drives req, so it counts as the first request cycle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        req           = 1'b0;
        complete      = 1'b0;
        abort         = 1'b0;
        capture_rdata = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_W'(1);
                if (mem_op) begin
                    if (misalign) begin
                        complete = 1'b1;
                        abort    = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (!i_dbus_gnt)    state_d = ST_REQ;
                        else if (is_store)  complete = 1'b1;
                        else                state_d = ST_WAIT;
                    end
                end
            end
            ST_REQ: begin
                if (timeout) begin
                    complete = 1'b1;
                    abort    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    req = 1'b1;
                    if (i_dbus_gnt) begin
                        if (is_store) begin
                            complete = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d  = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (timeout) begin
                    complete = 1'b1;
                    abort    = 1'b1;
                    state_d  = ST_IDLE;
                end else if (i_dbus_rvalid) begin
                    complete      = 1'b1;
                    capture_rdata = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall = (mem_op | (state_q != ST_IDLE)) & ~complete;

    always_comb begin
        p4p5_d = P4P5_BUBBLE;
        if (!stall) begin
            p4p5_d.pc_next   = i_p3p4.pc_next;
            p4p5_d.ctrl      = i_p3p4.ctrl;
            p4p5_d.alu_out   = i_p3p4.alu_out;
            p4p5_d.insn      = i_p3p4.insn;
            p4p5_d.mem_rdata = capture_rdata ? load_data : 32'h0;
        end
    end

    // NOTE: bus-facing outputs are gated by i_rst_n so a reset abandons an access without waiting for a clock edge.
    assign o_dbus_req   = i_rst_n & req;
    assign o_dbus_we    = o_dbus_req & is_store;
    assign o_dbus_addr  = o_dbus_req ? {i_p3p4.alu_out[31:2], 2'b00} : 32'h0;
    assign o_dbus_wdata = o_dbus_we ? store_data : 32'h0;
    assign o_dbus_wstrb = o_dbus_we ? store_strb : 4'h0;
    assign o_stall      = i_rst_n & stall;
    assign o_bus_err    = i_rst_n & abort;
    assign o_p4p5       = p4p5_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p4p5_q  <= P4P5_BUBBLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p4p5_q  <= p4p5_d;
        end
    end

endmodule
